// File: rtl/alu_cmd_queue.sv
// Command FIFO feeding the registered 4-bit ALU: valid/ready push side,
// paced single-command issue onto registered a/b/opcode, plus debug counters.
module alu_cmd_queue #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic              issue_en,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [OP_W-1:0]   opcode,
  output logic              out_valid,
  output logic [CNT_W-1:0]  count,
  output logic [7:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 2 * DATA_W + OP_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Ready depends only on registered count, so a same-cycle pop never frees a slot.
  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = issue_en && (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b, in_opcode};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      a         <= '0;
      b         <= '0;
      opcode    <= '0;
      out_valid <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      out_valid <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr            <= rd_ptr + 1'b1;
        {a, b, opcode}    <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue; issued commands are checked against a
// scoreboard queue filled when the bench pushes.
module tb_alu_cmd_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [1:0] in_opcode = '0;
  logic       issue_en = 1'b0;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] opcode;
  logic       out_valid;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  logic [9:0] sb[$];

  alu_cmd_queue #(.DATA_W(4), .OP_W(2), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .issue_en(issue_en),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of stimulus; the scoreboard learns what the queue will accept.
  task automatic step(input logic v, input logic [3:0] va, input logic [3:0] vb,
                      input logic [1:0] vop, input logic ie);
    logic acc;
    logic pp;
    in_valid = v; in_a = va; in_b = vb; in_opcode = vop; issue_en = ie;
    acc = v && (m_cnt != 4);
    pp  = ie && (m_cnt != 0);
    @(posedge clk);
    if (acc) sb.push_back({va, vb, vop});
    m_cnt = m_cnt + (acc ? 1 : 0) - (pp ? 1 : 0);
    #1;
  endtask

  task automatic idle(input logic ie);
    step(1'b0, 4'd0, 4'd0, 2'd0, ie);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: got a=%0d b=%0d op=%0d expected none", a, b, opcode);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        check("issue_a", a, e[9:6]);
        check("issue_b", b, e[5:2]);
        check("issue_op", opcode, e[1:0]);
      end
    end
  end

  initial begin
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_drop", drop_cnt, 0);
    #10 rst = 1'b1;

    // Single command, push and issue_en together on an empty queue
    step(1'b1, 4'd3, 4'd5, 2'd0, 1'b1);
    check("t1_count1", count, 1);
    check("t1_nobypass", out_valid, 0);
    idle(1'b1);
    check("t1_valid", out_valid, 1);
    check("t1_a", a, 3);
    check("t1_b", b, 5);
    check("t1_op", opcode, 0);
    check("t1_count0", count, 0);
    idle(1'b1);
    check("t1_valid_low", out_valid, 0);
    check("t1_hold_a", a, 3);
    check("t1_hold_b", b, 5);
    check("t1_hold_op", opcode, 0);

    // Fill, drop three, then drain in order
    step(1'b1, 4'd1, 4'd2, 2'd0, 1'b0);
    step(1'b1, 4'd3, 4'd4, 2'd1, 1'b0);
    step(1'b1, 4'd5, 4'd6, 2'd2, 1'b0);
    step(1'b1, 4'd7, 4'd8, 2'd3, 1'b0);
    check("t2_full_count", count, 4);
    check("t2_full_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd15, 4'd15, 2'd3, 1'b0);
    check("t2_drop3", drop_cnt, 3);
    check("t2_count_held", count, 4);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("t2_pulse", out_valid, 1);
    end
    check("t2_empty", count, 0);
    idle(1'b1);
    check("t2_valid_low", out_valid, 0);

    // Full with push and issue on the same edge
    step(1'b1, 4'd10, 4'd1, 2'd0, 1'b0);
    step(1'b1, 4'd11, 4'd2, 2'd1, 1'b0);
    step(1'b1, 4'd12, 4'd3, 2'd2, 1'b0);
    step(1'b1, 4'd13, 4'd4, 2'd3, 1'b0);
    step(1'b1, 4'd14, 4'd5, 2'd0, 1'b1);
    check("t3_count3", count, 3);
    check("t3_drop4", drop_cnt, 4);
    check("t3_valid", out_valid, 1);
    check("t3_ready", in_ready, 1);
    step(1'b1, 4'd14, 4'd5, 2'd0, 1'b1);
    check("t3_pushpop_count", count, 3);
    check("t3_drop_same", drop_cnt, 4);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("t3_drained", count, 0);
    idle(1'b0);

    // Streaming ten commands through a depth-1 steady state
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'(i), 4'(15 - i), 2'(i % 4), 1'b1);
      if (i == 0) check("t4_warm_valid", out_valid, 0);
      else check("t4_stream_valid", out_valid, 1);
      check("t4_count1", count, 1);
    end
    idle(1'b1);
    check("t4_last_valid", out_valid, 1);
    check("t4_count0", count, 0);
    idle(1'b0);

    // Asynchronous reset with entries pending and an issue just presented
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 4), 4'(i + 8), 2'(i), 1'b0);
    idle(1'b1);
    check("t5_pre_count", count, 3);
    check("t5_pre_valid", out_valid, 1);
    #1 rst = 1'b0;
    #1;
    sb.delete();
    m_cnt = 0;
    check("t5_rst_count", count, 0);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_a", a, 0);
    check("t5_rst_b", b, 0);
    check("t5_rst_op", opcode, 0);
    check("t5_rst_drop", drop_cnt, 0);
    check("t5_rst_ready", in_ready, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    step(1'b1, 4'd9, 4'd9, 2'd2, 1'b1);
    check("t5_count1", count, 1);
    idle(1'b1);
    check("t5_valid", out_valid, 1);
    check("t5_a", a, 9);
    check("t5_b", b, 9);
    check("t5_op", opcode, 2);
    check("t5_count0", count, 0);
    idle(1'b0);

    // Drop counter saturation
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 4'(i), 2'(i), 1'b0);
    for (int i = 0; i < 250; i++) step(1'b1, 4'd15, 4'd0, 2'd1, 1'b0);
    check("t6_drop250", drop_cnt, 250);
    for (int i = 0; i < 50; i++) step(1'b1, 4'd15, 4'd0, 2'd1, 1'b0);
    check("t6_drop_sat", drop_cnt, 255);
    check("t6_count", count, 4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);
    check("t6_drained", count, 0);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
- Upstream feeder stage for the registered 4-bit ALU.
- Buffers operand/opcode commands from a producer using a valid/ready handshake.
- Issues at most one command per clock to the ALU's a/b/opcode inputs, under an issue-enable that lets downstream control pace it.
- Provides occupancy and a saturating drop counter for debug.

Parameters:
- DATA_W, 4, operand width of a and b.
- OP_W, 2, opcode width.
- DEPTH, 4, number of command entries; power of 2, minimum 2.
- CNT_W, 3, width of count; must hold the value DEPTH, i.e. log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset; 0 = reset.
- in_valid  input  1  producer presents a command.
- in_ready  output  1  queue can accept; combinational, equals (count != DEPTH).
- in_a  input  DATA_W  operand A.
- in_b  input  DATA_W  operand B.
- in_opcode  input  OP_W  ALU opcode (00 add, 01 mul, 10 or, 11 and); passed through unchanged.
- issue_en  input  1  downstream permits an issue this cycle.
- a  output  DATA_W  registered operand A to the ALU.
- b  output  DATA_W  registered operand B to the ALU.
- opcode  output  OP_W  registered opcode to the ALU.
- out_valid  output  1  registered; 1 for exactly the cycle after an issue edge.
- count  output  CNT_W  registered number of stored entries, 0..DEPTH.
- drop_cnt  output  8  registered saturating count of rejected push attempts.

Behaviour:
- Reset (rst low, asynchronous, any time including mid-operation):
  - write/read pointers = 0, count = 0, a = b = opcode = 0, out_valid = 0, drop_cnt = 0.
  - All stored entries are discarded.
  - in_ready reads 1 while in reset.
  - Storage array contents need no reset.
- Push: at a rising edge with in_valid=1 and in_ready=1.
  - {in_a, in_b, in_opcode} is written at the write pointer.
  - Write pointer advances modulo DEPTH.
- Pop/issue: at a rising edge with issue_en=1 and count != 0.
  - Head entry is loaded into a/b/opcode and out_valid is set to 1.
  - Read pointer advances modulo DEPTH.
- No issue at an edge (issue_en=0 or count=0):
  - out_valid = 0.
  - a/b/opcode hold their previous values; they are not zeroed.
- Count update per edge: push only = +1; pop only = -1; both or neither = unchanged.
- Latency:
  - A command pushed at edge N is poppable no earlier than edge N+1; it appears on a/b/opcode after edge N+1. There is no bypass path.
  - It is issued in FIFO order behind older entries.
- Empty (count=0) with push and issue_en both asserted on the same edge:
  - push occurs, no pop, out_valid = 0, count becomes 1.
- Full (count=DEPTH):
  - in_ready = 0.
  - A simultaneous issue pops an entry, but in_ready is not raised combinationally from issue_en. The push is refused that cycle and accepted on the next edge.
- Pointer wrap: entry DEPTH-1 is followed by entry 0. Ordering is preserved across the wrap.
- Drop counter: at each edge with in_valid=1 and in_ready=0, drop_cnt increments by 1, saturating at 255.
- Producer rule: in_a/in_b/in_opcode are sampled only on accepted edges. Changing them while in_ready=0 has no effect.
- Widths: data is stored and issued bit-exact; no arithmetic on the data path.
- Pointers are log2(DEPTH) bits.
- count never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then push {a=3, b=5, op=00} at edge 1 with issue_en=1 -> count=1 after edge 1; after edge 2: a=3, b=5, opcode=00, out_valid=1, count=0; after edge 3: out_valid=0, a/b/opcode still 3/5/00.
- issue_en=0; push 4 commands (1,2,op00), (3,4,op01), (5,6,op10), (7,8,op11) -> count=4, in_ready=0. A 5th push attempt held 3 cycles -> drop_cnt=3. Then issue_en=1 -> 4 consecutive out_valid pulses in push order.
- Full queue with in_valid=1 and issue_en=1 on the same edge -> count stays 4-1=3, push refused, drop_cnt+1; next edge push accepted, count=3 (pop and push).
- Streaming with in_valid=1 and issue_en=1 continuously for 10 commands (a=i, b=15-i) -> after warm-up, out_valid=1 every cycle, count steady at 1, pointers wrap twice, output order matches input.
- Assert rst=0 asynchronously mid-cycle with count=3 and out_valid=1 -> all outputs go to 0 immediately without a clock edge. After release, a push of (9,9,op10) is issued first, with no stale entries.
- Hold in_valid=1 against a full queue for 300 cycles -> drop_cnt saturates at 255 and does not wrap.
